edge_output_stage: RTL and testbench
====================================

EDGE_OUTPUT_STAGE -- requirements
Module: edge_output_stage

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 clk_en  input  1  one 32-bit word on in_data is presented this cycle by the convolution datapath.
REQ-005 in_data  input  32  four 8-bit filter magnitudes; lane 0 = bits 7:0 = leftmost pixel.
REQ-006 threshold  input  8  magnitude threshold, sampled on every accepted word.
REQ-007 frame_start  input  1  single-cycle pulse that arms capture of one frame.
REQ-008 stall  output  1  back-pressure to upstream; a word is accepted only when clk_en=1 and stall=0.
REQ-009 out_data  output  32  processed word.
REQ-010 out_valid  output  1  out_data holds a word.
REQ-011 out_ready  input  1  consumer accepts; transfer occurs when out_valid=1 and out_ready=1.
REQ-012 frame_done  output  1  one-cycle pulse when the last word of a frame has been transferred.

Function
REQ-013 Constants: W = `ADDRESSES_PER_ROW (words per row); R = `ROWS_PER_FRAME; FILL_WORDS = W+1; FRAME_WORDS = R*W.
REQ-014 The FSM SHALL have the states IDLE, FILL, STREAM and DONE.
REQ-015 IDLE: input words SHALL be discarded; frame_start moves to FILL and clears col, row and the input count.
REQ-016 FILL: the first FILL_WORDS accepted words SHALL be discarded (line-buffer and latch priming); the block then moves to STREAM.
REQ-017 STREAM: each accepted word SHALL be processed and pushed into the output buffer; after the input count reaches FRAME_WORDS, the block moves to DONE.
REQ-018 DONE: stall=1; when the output buffer is empty, frame_done SHALL pulse for one cycle and the FSM returns to IDLE.
REQ-019 frame_start outside IDLE SHALL be ignored.
REQ-020 col SHALL wrap from W-1 to 0 and increment row; both counters SHALL advance on every accepted word in FILL and STREAM.
REQ-021 Border blanking: lane 0 SHALL be forced to 0 when col==0, and lane 3 SHALL be forced to 0 when col==W-1.
REQ-022 Per lane, value < threshold SHALL become 0x00; otherwise see REQ-029. Comparison SHALL be unsigned 8-bit, and equality counts as passing.
REQ-023 Latency SHALL be one cycle from the accepted word to out_valid with an empty buffer.
REQ-024 The output buffer SHALL be 2 entries, FIFO order; stall=1 when it is full (combinational from count) or when the state is DONE.
REQ-025 A simultaneous push and pop at count 1 SHALL leave count 1 and SHALL lose no data; a pop with count 0 SHALL be impossible (out_valid=0).
REQ-026 out_data SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-027 rst SHALL force state IDLE, col=row=0, input count 0, buffer empty, out_valid=0, out_data=0, stall=0 and frame_done=0 immediately, with no clock edge required.
REQ-028 A reset in mid-frame SHALL drop all buffered words; the next frame requires a new frame_start.

Configuration
REQ-029 With EDGE_BINARY_EN defined, passing lanes SHALL output 0xFF; without it, passing lanes SHALL output the original magnitude. Blanking and thresholding are otherwise identical in both cases.

Structure
REQ-030 W, R, FILL_WORDS, FRAME_WORDS and the state encodings SHALL live in the shared definitions include.
REQ-031 The 2-entry buffer SHALL be a sub-module named skid_buffer_32, which has the ports clk, rst, push, din, pop, dout, valid and full.

Verification (bench overrides W=4, R=3)
REQ-032 rst mid-STREAM with 2 words buffered -> out_valid=0, stall=0 and state IDLE in the same cycle; no further output until frame_start.
REQ-033 frame_start, 12 words 0x80808080, threshold 0x40, out_ready=1 -> first 5 dropped; 7 words out; the col==0 word is 0x80808000 and the col==3 word is 0x00808080; frame_done pulses after the 7th transfer.
REQ-034 threshold 0x80, lanes {0x7F,0x80,0x81,0x00} at col 1 -> {0x00,0x80,0x81,0x00} without EDGE_BINARY_EN; {0x00,0xFF,0xFF,0x00} with it.
REQ-035 out_ready=0 for 4 cycles during STREAM -> stall rises after 2 pushes; clk_en words sent while stall=1 are not counted; on release, order is preserved and the total count is still 7.
REQ-036 At count 1, push and pop in the same cycle -> count stays 1; the popped word is the older word and the newer word follows next.
REQ-037 frame_start pulsed during STREAM -> ignored; col and row continue and 7 words are still output.

Source files
------------

// File: rtl/edge_output_stage_pkg.sv
// ----------------------------------------------------------------------------
// edge_output_stage_pkg
// Shared definitions for the edge output stage: frame geometry, derived word
// counts, counter widths and FSM state encodings.
//
// Geometry comes from the build macros ADDRESSES_PER_ROW (words per row) and
// ROWS_PER_FRAME. When the build does not supply them, a small 4x3 frame is
// assumed.
//
// No ports (package).
// ----------------------------------------------------------------------------
`ifndef ADDRESSES_PER_ROW
`define ADDRESSES_PER_ROW 4
`endif
`ifndef ROWS_PER_FRAME
`define ROWS_PER_FRAME 3
`endif

package edge_output_stage_pkg;

    localparam int W           = `ADDRESSES_PER_ROW;
    localparam int R           = `ROWS_PER_FRAME;
    // One full row plus one word primes the line buffer and the latches.
    localparam int FILL_WORDS  = W + 1;
    localparam int FRAME_WORDS = R * W;

    localparam int COL_W = (W > 1) ? $clog2(W) : 1;
    localparam int ROW_W = (R > 1) ? $clog2(R) : 1;
    localparam int CNT_W = $clog2(FRAME_WORDS + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    typedef logic [7:0] lane_t;

endpackage

// File: rtl/skid_buffer_32.sv
// ----------------------------------------------------------------------------
// skid_buffer_32
// Two-entry FIFO holding 32-bit words between the edge datapath and the
// consumer. The head entry drives dout directly, so dout stays stable until
// it is popped.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous active-high reset (empties the buffer, dout=0)
//   push  in   write din this cycle (ignored when full unless a pop frees room)
//   din   in   32-bit word to write
//   pop   in   remove the head word (ignored when empty)
//   dout  out  head word
//   valid out  buffer holds at least one word
//   full  out  buffer holds two words
// ----------------------------------------------------------------------------
module skid_buffer_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] din,
    input  logic        pop,
    output logic [31:0] dout,
    output logic        valid,
    output logic        full
);

    logic [1:0]  count;
    logic [31:0] head;
    logic [31:0] tail;
    logic        do_push;
    logic        do_pop;

    assign dout    = head;
    assign valid   = (count != 2'd0);
    assign full    = (count == 2'd2);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 2'd0;
            head  <= 32'd0;
            tail  <= 32'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        head <= din;
                    end else begin
                        tail <= din;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the older word leaves first.
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/edge_output_stage.sv
// ----------------------------------------------------------------------------
// edge_output_stage
// Final stage of the edge-detection pipeline. Captures one frame per
// frame_start, discards the priming words, blanks the left/right border
// lanes, thresholds each 8-bit magnitude and queues the result in a 2-entry
// buffer toward the consumer.
//
// Build option: EDGE_BINARY_EN -- when defined, lanes at or above threshold
// output 0xFF; otherwise they keep their original magnitude.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   clk_en      in   a word is offered on in_data this cycle
//   in_data     in   four 8-bit magnitudes, lane 0 (bits 7:0) is leftmost
//   threshold   in   magnitude threshold, used on every accepted word
//   frame_start in   pulse arming capture of one frame (honoured in IDLE only)
//   stall       out  back-pressure; a word is accepted when clk_en && !stall
//   out_data    out  processed word
//   out_valid   out  out_data holds a word
//   out_ready   in   consumer accepts out_data this cycle
//   frame_done  out  one-cycle pulse after the last word of a frame left
// ----------------------------------------------------------------------------
module edge_output_stage
    import edge_output_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [31:0] in_data,
    input  logic [7:0]  threshold,
    input  logic        frame_start,
    output logic        stall,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        frame_done
);

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(R - 1);
    localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_WORDS - 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(FRAME_WORDS - 1);

    logic [1:0]       state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [CNT_W-1:0] in_cnt;

    logic        accept;
    logic        counting;
    logic        frame_last;
    logic        buf_full;
    logic        buf_valid;
    logic        pop;
    logic [31:0] word_p0;
    logic        vld_p0;

    function automatic lane_t lane_thresh(input lane_t mag, input lane_t thr);
        if (mag < thr) begin
            return 8'h00;
        end
`ifdef EDGE_BINARY_EN
        return 8'hFF;
`else
        return mag;
`endif
    endfunction

    assign stall     = buf_full || (state == ST_DONE);
    assign accept    = clk_en && !stall;
    assign counting  = accept && ((state == ST_FILL) || (state == ST_STREAM));
    assign pop       = buf_valid && out_ready;
    assign out_valid = buf_valid;

    // The word counter and the geometry counters track the same words, so
    // both land on the frame's last word together.
    assign frame_last = (in_cnt == LAST_WORD) && (row == ROW_LAST) && (col == COL_LAST);

    // ---- stage p0: blank border lanes, threshold, push into the buffer ----
    always_comb begin
        word_p0 = {lane_thresh(in_data[31:24], threshold),
                   lane_thresh(in_data[23:16], threshold),
                   lane_thresh(in_data[15:8],  threshold),
                   lane_thresh(in_data[7:0],   threshold)};
        if (col == '0) begin
            word_p0[7:0] = 8'h00;
        end
        if (col == COL_LAST) begin
            word_p0[31:24] = 8'h00;
        end
    end

    assign vld_p0 = accept && (state == ST_STREAM);

    skid_buffer_32 u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (vld_p0),
        .din   (word_p0),
        .pop   (pop),
        .dout  (out_data),
        .valid (buf_valid),
        .full  (buf_full)
    );

    // ---- control: frame FSM and position counters ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            col        <= '0;
            row        <= '0;
            in_cnt     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (counting) begin
                in_cnt <= in_cnt + 1'b1;
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        col    <= '0;
                        row    <= '0;
                        in_cnt <= '0;
                        state  <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (accept && (in_cnt == FILL_LAST)) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (accept && frame_last) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!buf_valid) begin
                        frame_done <= 1'b1;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edge_output_stage.sv
// ----------------------------------------------------------------------------
// tb_edge_output_stage
// Directed bench for edge_output_stage with a 4-word x 3-row frame.
// Inputs change 1 time unit after the rising edge; outputs are observed on
// the falling edge.
// ----------------------------------------------------------------------------
module tb_edge_output_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [31:0] in_data;
    logic [7:0]  threshold;
    logic        frame_start;
    logic        stall;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        frame_done;

    int n_checks = 0;
    int n_errors = 0;
    int stall_waits;
    int done_cnt;
    int done_at;
    logic [31:0] xfer_q[$];

    logic [31:0] exp_a [7];
    logic [31:0] exp_c [7];
    logic [31:0] words [12];

    always #5 clk = ~clk;

    edge_output_stage dut (
        .clk         (clk),
        .rst         (rst),
        .clk_en      (clk_en),
        .in_data     (in_data),
        .threshold   (threshold),
        .frame_start (frame_start),
        .stall       (stall),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .frame_done  (frame_done)
    );

    // Transfer and frame_done monitor.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            xfer_q.push_back(out_data);
        end
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_at  = xfer_q.size();
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        xfer_q.delete();
        done_cnt    = 0;
        done_at     = -1;
        stall_waits = 0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Offer one word and hold it until it is accepted.
    task automatic send_word(input logic [31:0] d);
        int guard;
        guard   = 0;
        in_data = d;
        clk_en  = 1'b1;
        @(negedge clk);
        while (stall && guard < 50) begin
            stall_waits++;
            guard++;
            @(negedge clk);
        end
        if (guard >= 50) begin
            check("send_timeout", 32'd1, 32'd0);
        end
        @(posedge clk);
        #1;
        clk_en = 1'b0;
    endtask

    task automatic send_range(input int first, input int last);
        for (int k = first; k <= last; k++) begin
            send_word(words[k]);
        end
    endtask

    task automatic wait_done(input string tag);
        int g;
        g = 0;
        while (done_cnt == 0 && g < 60) begin
            tick();
            g++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
        repeat (3) tick();
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    task automatic check_words(input string tag, input logic [31:0] exp [7]);
        logic [31:0] got;
        check({tag, "_count"}, 32'(xfer_q.size()), 32'd7);
        for (int i = 0; i < 7; i++) begin
            got = (i < xfer_q.size()) ? xfer_q[i] : 32'hxxxxxxxx;
            check($sformatf("%s_w%0d", tag, i), got, exp[i]);
        end
    endtask

    initial begin
        // Stream words 5..11 sit at cols 1,2,3,0,1,2,3.
        exp_a = '{32'h80808080, 32'h80808080, 32'h00808080, 32'h80808000,
                  32'h80808080, 32'h80808080, 32'h00808080};
        exp_c = '{32'h15151515, 32'h16161616, 32'h00171717, 32'h18181800,
                  32'h19191919, 32'h1A1A1A1A, 32'h001B1B1B};

        rst         = 1'b1;
        clk_en      = 1'b0;
        in_data     = 32'd0;
        threshold   = 8'd0;
        frame_start = 1'b0;
        out_ready   = 1'b0;
        clear_mon();

        // Reset state before any clock edge.
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic frame: priming words dropped, borders blanked, one word per
        // cycle with push and pop overlapping at occupancy 1.
        for (int k = 0; k < 12; k++) words[k] = 32'h80808080;
        threshold = 8'h40;
        out_ready = 1'b1;
        clear_mon();
        pulse_start();
        send_range(0, 11);
        wait_done("a");
        check_words("a", exp_a);
        check("a_done_after", 32'(done_at), 32'd7);
        check("a_no_stall", 32'(stall_waits), 32'd0);

        // Threshold boundaries at col 1.
        for (int k = 0; k < 12; k++) words[k] = 32'h00000000;
        words[5]  = 32'h0081807F;
        threshold = 8'h80;
        clear_mon();
        pulse_start();
        send_range(0, 11);
        wait_done("b");
        check("b_count", 32'(xfer_q.size()), 32'd7);
`ifdef EDGE_BINARY_EN
        check("b_thresh", (xfer_q.size() > 0) ? xfer_q[0] : 32'hxxxxxxxx, 32'h00FFFF00);
`else
        check("b_thresh", (xfer_q.size() > 0) ? xfer_q[0] : 32'hxxxxxxxx, 32'h00818000);
`endif

        // Back-pressure: consumer stalls, buffer fills after two pushes,
        // words offered during stall are not taken.
        for (int k = 0; k < 12; k++) words[k] = {4{8'(8'h10 + k)}};
        threshold = 8'h00;
        out_ready = 1'b0;
        clear_mon();
        pulse_start();
        send_range(0, 6);
        check("c_stall_full", 32'(stall), 32'd1);
        in_data = 32'hDEADBEEF;
        clk_en  = 1'b1;
        repeat (3) tick();
        check("c_stall_held", 32'(stall), 32'd1);
        check("c_none_out", 32'(xfer_q.size()), 32'd0);
        out_ready = 1'b1;
        send_range(7, 11);
        wait_done("c");
        check_words("c", exp_c);

        // frame_start during STREAM is ignored.
        for (int k = 0; k < 12; k++) words[k] = 32'h80808080;
        threshold = 8'h40;
        clear_mon();
        pulse_start();
        send_range(0, 6);
        frame_start = 1'b1;
        send_word(words[7]);
        frame_start = 1'b0;
        send_range(8, 11);
        wait_done("e");
        check_words("e", exp_a);

        // Reset mid-STREAM with two words buffered.
        out_ready = 1'b0;
        clear_mon();
        pulse_start();
        send_range(0, 6);
        check("f_pre_full", 32'(stall), 32'd1);
        rst = 1'b1;
        #1;
        check("f_rst_valid", 32'(out_valid), 32'd0);
        check("f_rst_stall", 32'(stall), 32'd0);
        check("f_rst_data", out_data, 32'd0);
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        send_range(0, 3);
        repeat (3) tick();
        check("f_idle_none", 32'(xfer_q.size()), 32'd0);
        check("f_idle_nodone", 32'(done_cnt), 32'd0);
        clear_mon();
        pulse_start();
        send_range(0, 11);
        wait_done("f");
        check_words("f", exp_a);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
